// File: rtl/aes256_decrypt_core_if.sv
// Host-side request/response bundle for aes256_decrypt_core.
interface aes256_decrypt_core_if;
    logic         en_i;
    logic         start_i;
    logic [127:0] ciphertext_i;
    logic [255:0] key_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] plaintext_o;

    modport master (output en_i, start_i, ciphertext_i, key_i,
                    input  busy_o, done_o, plaintext_o);
    modport slave  (input  en_i, start_i, ciphertext_i, key_i,
                    output busy_o, done_o, plaintext_o);
endinterface

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: forward key expansion into a round-key store, then one
// inverse round per cycle. Optional macro KEY_CACHE_EN skips expansion on a repeated key.
module aes256_decrypt_core #(
    parameter int unsigned NR       = 14,
    parameter int unsigned NK_WORDS = 8
) (
    input logic                  clk_i,
    input logic                  rst_n,
    aes256_decrypt_core_if.slave bus
);
    localparam int unsigned BW  = 128;
    localparam int unsigned CW  = 4;
    localparam int unsigned NRK = NR + 1;
    localparam logic [CW-1:0] LAST_RK   = CW'(NR);
    localparam logic [CW-1:0] FIRST_RND = CW'(NR - 1);

    if (NR != 14 || NK_WORDS != 8) begin : g_bad_cfg
        $error("aes256_decrypt_core supports only NR=14 and NK_WORDS=8");
    end

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse computed as a^254, which maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [BW-1:0] inv_shift_rows(input logic [BW-1:0] s);
        logic [BW-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[BW-1-8*(4*c+r) -: 8] = s[BW-1-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [BW-1:0] inv_sub_bytes(input logic [BW-1:0] s);
        logic [BW-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[BW-1-8*i -: 8] = inv_sbox(s[BW-1-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [BW-1:0] inv_mix_columns(input logic [BW-1:0] s);
        logic [BW-1:0] o;
        logic [7:0]    a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[BW-1-32*c  -: 8];
            a1 = s[BW-9-32*c  -: 8];
            a2 = s[BW-17-32*c -: 8];
            a3 = s[BW-25-32*c -: 8];
            o[BW-1-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   text_q, text_d;
    logic [BW-1:0]   pt_q, pt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   rk_q [NRK];
    logic            rk_load, rk_wr;
    logic            start_acc, cache_hit;
    logic [CW-1:0]   km1, km2;
    logic [31:0]     last_w, temp_w;
    logic [7:0]      rcon;
    logic [BW-1:0]   prev2, rk_new, rk_sel, inv_t;
    logic [31:0]     w0, w1, w2, w3;

    assign start_acc = bus.start_i && (state_q == S_IDLE || state_q == S_DONE);

    // Next round key from the two previous ones; cnt_q is the key index during KEYEXP.
    always_comb begin
        km1    = cnt_q - CW'(1);
        km2    = cnt_q - CW'(2);
        prev2  = rk_q[km2];
        last_w = rk_q[km1][31:0];
        rcon   = 8'h01 << (cnt_q[3:1] - 3'd1);
        temp_w = cnt_q[0] ? sub_word(last_w)
                          : (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon, 24'h0});
        w0     = prev2[127:96] ^ temp_w;
        w1     = prev2[95:64]  ^ w0;
        w2     = prev2[63:32]  ^ w1;
        w3     = prev2[31:0]   ^ w2;
        rk_new = {w0, w1, w2, w3};
    end

    // Shared inverse-round datapath; cnt_q selects the round key (14 in INIT, 0 in FINAL).
    always_comb begin
        rk_sel = rk_q[cnt_q];
        inv_t  = inv_sub_bytes(inv_shift_rows(text_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        text_d  = text_q;
        pt_d    = pt_q;
        rk_load = 1'b0;
        rk_wr   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    text_d = bus.ciphertext_i;
                    if (cache_hit) begin
                        state_d = S_INIT;
                        cnt_d   = LAST_RK;
                    end else begin
                        state_d = S_KEYEXP;
                        cnt_d   = CW'(2);
                        rk_load = 1'b1;
                    end
                end
            end
            S_KEYEXP: begin
                rk_wr = 1'b1;
                if (cnt_q == LAST_RK) state_d = S_INIT;
                else                  cnt_d   = cnt_q + CW'(1);
            end
            S_INIT: begin
                text_d  = text_q ^ rk_sel;
                cnt_d   = FIRST_RND;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                text_d = inv_mix_columns(inv_t ^ rk_sel);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                pt_d    = inv_t ^ rk_sel;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d inside {S_KEYEXP, S_INIT, S_ROUND, S_FINAL};
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            text_q  <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            text_q  <= text_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Round-key store carries no reset; it is always rewritten before it is read.
    always_ff @(posedge clk_i) begin
        if (bus.en_i) begin
            if (rk_load) begin
                rk_q[0] <= bus.key_i[2*BW-1:BW];
                rk_q[1] <= bus.key_i[BW-1:0];
            end
            if (rk_wr) rk_q[cnt_q] <= rk_new;
        end
    end

`ifdef KEY_CACHE_EN
    logic [2*BW-1:0] cache_key_q;
    logic            cache_vld_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else if (bus.en_i) begin
            if (state_q == S_KEYEXP && cnt_q == LAST_RK) begin
                cache_key_q <= {rk_q[0], rk_q[1]};
                cache_vld_q <= 1'b1;
            end else if (start_acc && !cache_hit) begin
                cache_vld_q <= 1'b0;
            end
        end
    end

    assign cache_hit = cache_vld_q && (bus.key_i == cache_key_q);
`else
    assign cache_hit = 1'b0;
`endif

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.plaintext_o = pt_q;
endmodule
